// File: rtl/nios2_debug_ocimem_arbiter.sv
// Shares the Nios II debug RAM between the JTAG debug slave and the CPU Avalon slave.
// Decodes JTAG strobes, round-robins contested grants, and keeps the monitor address/MonDReg.
module nios2_debug_ocimem_arbiter #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned JTAG_FIRST = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [37:0]       jdo,
  input  logic [ADDR_W-1:0] av_address,
  input  logic              av_read,
  input  logic              av_write,
  input  logic [31:0]       av_writedata,
  output logic [31:0]       av_readdata,
  output logic              av_waitrequest,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_wren,
  output logic [31:0]       ram_wrdata,
  input  logic [31:0]       ram_rddata,
  output logic [31:0]       MonDReg,
  output logic              mon_busy,
  output logic              jtag_overrun
);

  localparam int unsigned DATA_W = 32;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] J_WR  = 3'd1;
  localparam logic [2:0] J_RD  = 3'd2;
  localparam logic [2:0] J_RDW = 3'd3;
  localparam logic [2:0] C_WR  = 3'd4;
  localparam logic [2:0] C_RD  = 3'd5;
  localparam logic [2:0] C_RDW = 3'd6;

  logic [2:0]        state, state_nxt;
  logic [ADDR_W-1:0] mon_addr;
  logic              jtag_pend, jtag_pend_wr;
  logic [DATA_W-1:0] jtag_data;
  logic              last_grant_jtag, last_grant_jtag_nxt;

  logic [ADDR_W-1:0] ram_address_nxt;
  logic              ram_wren_nxt;
  logic [DATA_W-1:0] ram_wrdata_nxt;
  logic              av_waitrequest_nxt;

  logic acc_a, acc_b, acc_n, drop;
  logic jreq, jreq_wr, creq, creq_wr;
  logic [DATA_W-1:0] jreq_data;
  logic grant_j, grant_c;
  logic j_done;
  logic unused_jdo;

  assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

  // Strobe acceptance: one strobe per cycle by priority, none while an op is outstanding.
  always_comb begin
    acc_a = take_action_ocimem_a & ~mon_busy;
    acc_b = take_action_ocimem_b & ~take_action_ocimem_a & ~mon_busy;
    acc_n = take_no_action_ocimem_a & ~take_action_ocimem_a & ~take_action_ocimem_b & ~mon_busy;
    if (mon_busy)
      drop = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    else
      drop = (take_action_ocimem_a & take_action_ocimem_b) |
             (take_action_ocimem_a & take_no_action_ocimem_a) |
             (take_action_ocimem_b & take_no_action_ocimem_a);
  end

  // A freshly accepted strobe competes in its own cycle; otherwise the latched op does.
  assign jreq      = jtag_pend | acc_b | acc_n;
  assign jreq_wr   = jtag_pend ? jtag_pend_wr : acc_b;
  assign jreq_data = jtag_pend ? jtag_data : jdo[34:3];
  assign creq      = av_read | av_write;
  assign creq_wr   = av_write;
  assign j_done    = (state == J_WR) || (state == J_RDW);

  // Next state, grant decision and next values of the registered RAM/Avalon outputs.
  always_comb begin
    state_nxt           = state;
    last_grant_jtag_nxt = last_grant_jtag;
    ram_address_nxt     = ram_address;
    ram_wren_nxt        = 1'b0;
    ram_wrdata_nxt      = ram_wrdata;
    av_waitrequest_nxt  = 1'b1;
    grant_j             = 1'b0;
    grant_c             = 1'b0;
    case (state)
      IDLE: begin
        if (jreq && (!creq || !last_grant_jtag))
          grant_j = 1'b1;
        else if (creq)
          grant_c = 1'b1;
        if (jreq && creq)
          last_grant_jtag_nxt = grant_j;
        if (grant_j) begin
          state_nxt       = jreq_wr ? J_WR : J_RD;
          ram_address_nxt = mon_addr;
          ram_wren_nxt    = jreq_wr;
          ram_wrdata_nxt  = jreq_data;
        end else if (grant_c) begin
          state_nxt          = creq_wr ? C_WR : C_RD;
          ram_address_nxt    = av_address;
          ram_wren_nxt       = creq_wr;
          ram_wrdata_nxt     = av_writedata;
          av_waitrequest_nxt = ~creq_wr;
        end
      end
      J_WR:    state_nxt = IDLE;
      J_RD:    state_nxt = J_RDW;
      J_RDW:   state_nxt = IDLE;
      C_WR:    state_nxt = IDLE;
      C_RD: begin
        state_nxt          = C_RDW;
        av_waitrequest_nxt = 1'b0;
      end
      C_RDW:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      last_grant_jtag <= (JTAG_FIRST == 0);
      ram_address     <= '0;
      ram_wren        <= 1'b0;
      ram_wrdata      <= '0;
      av_waitrequest  <= 1'b1;
    end else begin
      state           <= state_nxt;
      last_grant_jtag <= last_grant_jtag_nxt;
      ram_address     <= ram_address_nxt;
      ram_wren        <= ram_wren_nxt;
      ram_wrdata      <= ram_wrdata_nxt;
      av_waitrequest  <= av_waitrequest_nxt;
    end
  end

  // JTAG command latch, monitor address counter and read-back register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mon_addr     <= '0;
      jtag_pend    <= 1'b0;
      jtag_pend_wr <= 1'b0;
      jtag_data    <= '0;
      mon_busy     <= 1'b0;
      MonDReg      <= '0;
      jtag_overrun <= 1'b0;
    end else begin
      if (acc_a && jdo[34])
        mon_addr <= jdo[17 +: ADDR_W];
      else if (j_done)
        mon_addr <= mon_addr + ADDR_W'(1);

      if (acc_b || acc_n) begin
        jtag_pend_wr <= acc_b;
        jtag_data    <= jdo[34:3];
      end
      if (grant_j)
        jtag_pend <= 1'b0;
      else if (acc_b || acc_n)
        jtag_pend <= 1'b1;

      if (acc_b || acc_n)
        mon_busy <= 1'b1;
      else if (j_done)
        mon_busy <= 1'b0;

      if (state == J_RDW)
        MonDReg <= ram_rddata;

      // A drop in the same cycle as an accepted address load leaves the flag set.
      if (drop)
        jtag_overrun <= 1'b1;
      else if (acc_a)
        jtag_overrun <= 1'b0;
    end
  end

  // RAM data is only valid in the wait cycle after the address, so read data passes straight through.
  assign av_readdata = (state == C_RDW) ? ram_rddata : '0;

endmodule

// File: tb/tb_nios2_debug_ocimem_arbiter.sv
// Directed bench for nios2_debug_ocimem_arbiter with a 1-cycle-latency RAM model.
module tb_nios2_debug_ocimem_arbiter;

  logic        clk;
  logic        reset_n;
  logic        take_a, take_b, take_n;
  logic [37:0] jdo;
  logic [7:0]  av_address;
  logic        av_read, av_write;
  logic [31:0] av_writedata;
  logic [31:0] av_readdata;
  logic        av_waitrequest;
  logic [7:0]  ram_address;
  logic        ram_wren;
  logic [31:0] ram_wrdata;
  logic [31:0] ram_rddata;
  logic [31:0] MonDReg;
  logic        mon_busy;
  logic        jtag_overrun;

  logic [31:0] mem [256];
  int checks;
  int errors;

  nios2_debug_ocimem_arbiter #(.ADDR_W(8), .JTAG_FIRST(1)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .take_action_ocimem_a    (take_a),
    .take_action_ocimem_b    (take_b),
    .take_no_action_ocimem_a (take_n),
    .jdo                     (jdo),
    .av_address              (av_address),
    .av_read                 (av_read),
    .av_write                (av_write),
    .av_writedata            (av_writedata),
    .av_readdata             (av_readdata),
    .av_waitrequest          (av_waitrequest),
    .ram_address             (ram_address),
    .ram_wren                (ram_wren),
    .ram_wrdata              (ram_wrdata),
    .ram_rddata              (ram_rddata),
    .MonDReg                 (MonDReg),
    .mon_busy                (mon_busy),
    .jtag_overrun            (jtag_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM, one-cycle read latency.
  always @(posedge clk) begin
    if (ram_wren) mem[ram_address] <= ram_wrdata;
    ram_rddata <= mem[ram_address];
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load_addr(input logic [7:0] a, input logic en);
    jdo = '0;
    jdo[34] = en;
    jdo[24:17] = a;
    take_a = 1'b1;
    cyc();
    take_a = 1'b0;
    jdo = '0;
  endtask

  task automatic jwrite(input string tag, input logic [31:0] d);
    jdo = '0;
    jdo[34:3] = d;
    take_b = 1'b1;
    cyc();
    take_b = 1'b0;
    jdo = '0;
    check({tag, "_busy_hi"}, 32'(mon_busy), 32'd1);
    check({tag, "_wren"}, 32'(ram_wren), 32'd1);
    cyc();
    check({tag, "_busy_lo"}, 32'(mon_busy), 32'd0);
  endtask

  task automatic jread(input string tag, input logic [31:0] prev, input logic [31:0] exp);
    take_n = 1'b1;
    cyc();
    take_n = 1'b0;
    cyc();
    check({tag, "_early"}, MonDReg, prev);
    cyc();
    check({tag, "_data"}, MonDReg, exp);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    take_a = 1'b0; take_b = 1'b0; take_n = 1'b0;
    jdo = '0;
    av_address = '0; av_read = 1'b0; av_write = 1'b0; av_writedata = '0;
    for (int i = 0; i < 256; i++) mem[i] = 32'hCAFE_0000 | 32'(i);

    // Reset values
    cyc(); cyc();
    check("rst_readdata", av_readdata, 32'h0);
    check("rst_wait", 32'(av_waitrequest), 32'd1);
    check("rst_addr", 32'(ram_address), 32'h0);
    check("rst_wren", 32'(ram_wren), 32'd0);
    check("rst_wrdata", ram_wrdata, 32'h0);
    check("rst_mondreg", MonDReg, 32'h0);
    check("rst_busy", 32'(mon_busy), 32'd0);
    check("rst_overrun", 32'(jtag_overrun), 32'd0);
    reset_n = 1'b1;
    cyc();

    // JTAG writes with auto-increment
    load_addr(8'h10, 1'b1);
    jwrite("wr_a", 32'hA);
    jwrite("wr_b", 32'hB);
    jwrite("wr_c", 32'hC);
    check("mem_10", mem[8'h10], 32'hA);
    check("mem_11", mem[8'h11], 32'hB);
    check("mem_12", mem[8'h12], 32'hC);
    jread("rd_13", 32'h0, 32'hCAFE_0013);

    // JTAG reads after reload
    load_addr(8'h10, 1'b1);
    jread("rd_10", 32'hCAFE_0013, 32'hA);
    jread("rd_11", 32'hA, 32'hB);

    // CPU write then read
    av_address = 8'h20; av_writedata = 32'h55; av_write = 1'b1;
    cyc();
    check("cwr_wait", 32'(av_waitrequest), 32'd0);
    check("cwr_wren", 32'(ram_wren), 32'd1);
    check("cwr_addr", 32'(ram_address), 32'h20);
    cyc();
    av_write = 1'b0;
    check("cwr_wait_hi", 32'(av_waitrequest), 32'd1);
    av_read = 1'b1;
    cyc();
    check("crd_wait1", 32'(av_waitrequest), 32'd1);
    cyc();
    check("crd_wait2", 32'(av_waitrequest), 32'd0);
    check("crd_data", av_readdata, 32'h55);
    cyc();
    av_read = 1'b0;
    check("crd_wait_hi", 32'(av_waitrequest), 32'd1);

    // Contention after reset: JTAG first, then CPU first
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    cyc();
    take_n = 1'b1; av_read = 1'b1; av_address = 8'h20;
    cyc();
    take_n = 1'b0;
    check("arb1_jaddr", 32'(ram_address), 32'h00);
    check("arb1_wait", 32'(av_waitrequest), 32'd1);
    cyc(); cyc();
    check("arb1_mondreg", MonDReg, 32'hCAFE_0000);
    cyc();
    check("arb1_caddr", 32'(ram_address), 32'h20);
    cyc();
    check("arb1_cwait", 32'(av_waitrequest), 32'd0);
    check("arb1_cdata", av_readdata, 32'h55);
    cyc();
    av_read = 1'b0;
    take_n = 1'b1; av_read = 1'b1;
    cyc();
    take_n = 1'b0;
    check("arb2_caddr", 32'(ram_address), 32'h20);
    check("arb2_busy", 32'(mon_busy), 32'd1);
    cyc();
    check("arb2_cwait", 32'(av_waitrequest), 32'd0);
    check("arb2_cdata", av_readdata, 32'h55);
    cyc();
    av_read = 1'b0;
    cyc();
    check("arb2_jaddr", 32'(ram_address), 32'h01);
    cyc(); cyc();
    check("arb2_mondreg", MonDReg, 32'hCAFE_0001);
    check("arb2_busy_lo", 32'(mon_busy), 32'd0);

    // Address wrap, overrun while busy, overrun clear
    load_addr(8'hFF, 1'b1);
    jdo = '0; jdo[34:3] = 32'h77; take_b = 1'b1;
    cyc();
    check("wrap_addr", 32'(ram_address), 32'hFF);
    jdo[34:3] = 32'h99;
    cyc();
    take_b = 1'b0; jdo = '0;
    check("ovr_set", 32'(jtag_overrun), 32'd1);
    check("ovr_nowren", 32'(ram_wren), 32'd0);
    cyc();
    check("ovr_nowren2", 32'(ram_wren), 32'd0);
    check("mem_ff", mem[8'hFF], 32'h77);
    jread("rd_wrap", 32'hCAFE_0001, 32'hCAFE_0000);
    check("ovr_sticky", 32'(jtag_overrun), 32'd1);
    load_addr(8'h00, 1'b0);
    check("ovr_clear", 32'(jtag_overrun), 32'd0);

    // Simultaneous strobes: address load wins, read dropped
    jdo = '0; jdo[34] = 1'b1; jdo[24:17] = 8'h05;
    take_a = 1'b1; take_n = 1'b1;
    cyc();
    take_a = 1'b0; take_n = 1'b0; jdo = '0;
    check("multi_ovr", 32'(jtag_overrun), 32'd1);
    check("multi_busy", 32'(mon_busy), 32'd0);
    jread("rd_05", 32'hCAFE_0000, 32'hCAFE_0005);

    // Reset during a CPU read
    av_address = 8'h20; av_read = 1'b1;
    cyc();
    check("crd_rst_addr", 32'(ram_address), 32'h20);
    reset_n = 1'b0;
    #1;
    check("crd_rst_wait", 32'(av_waitrequest), 32'd1);
    check("crd_rst_mondreg", MonDReg, 32'h0);
    check("crd_rst_raddr", 32'(ram_address), 32'h0);
    av_read = 1'b0;
    cyc(); cyc();
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("post_rst_wren", 32'(ram_wren), 32'd0);
      check("post_rst_wait", 32'(av_waitrequest), 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nios2_debug_ocimem_arbiter.md
Name: nios2_debug_ocimem_arbiter

Overview:
- Sysclk-domain controller that shares the Nios II on-chip debug memory (single-port RAM, 1-cycle read latency) between two requesters: the JTAG debug slave and the CPU's Avalon debug-memory slave.
- JTAG requester: single-cycle take_action/take_no_action strobes plus the 38-bit jdo word; the block decodes them into address load, write and auto-increment reads.
- Round-robin arbitration, JTAG command latching, a monitor address counter and the MonDReg read-back register.

Parameters:
- ADDR_W, 8, debug RAM word-address width; depth is 2^ADDR_W words of 32 bits.
- JTAG_FIRST, 1, when 1 the first contested grant after reset goes to JTAG; when 0 it goes to the CPU.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- take_action_ocimem_a  in  1  JTAG address-load strobe, one cycle wide.
- take_action_ocimem_b  in  1  JTAG write strobe, one cycle wide.
- take_no_action_ocimem_a  in  1  JTAG read strobe, one cycle wide.
- jdo  in  38  JTAG data word; valid in the strobe cycle.
- av_address  in  ADDR_W  CPU word address.
- av_read  in  1  CPU read request.
- av_write  in  1  CPU write request.
- av_writedata  in  32  CPU write data.
- av_readdata  out  32  CPU read data; valid when av_read=1 and av_waitrequest=0.
- av_waitrequest  out  1  CPU stall.
- ram_address  out  ADDR_W  RAM address.
- ram_wren  out  1  RAM write enable.
- ram_wrdata  out  32  RAM write data.
- ram_rddata  in  32  RAM read data; valid 1 cycle after the address is presented.
- MonDReg  out  32  JTAG read-back register.
- mon_busy  out  1  a JTAG operation is pending or in flight.
- jtag_overrun  out  1  sticky flag: a JTAG strobe was dropped.

Behaviour:
- Reset values: av_readdata=0, av_waitrequest=1, ram_address=0, ram_wren=0, ram_wrdata=0, MonDReg=0, mon_busy=0, jtag_overrun=0. mon_addr=0, pending cleared, state=IDLE, last_grant set so the JTAG_FIRST winner is favoured.
- Reset asserted mid-operation aborts the operation. The pending JTAG op is discarded. No RAM write is issued after reset deasserts until a new request arrives.

JTAG decode, in the strobe cycle:
- take_action_ocimem_a with jdo[34]=1: mon_addr <= jdo[17 +: ADDR_W]. No RAM access. With jdo[34]=0 the strobe is a no-op.
- take_action_ocimem_a (either jdo[34] value) also clears jtag_overrun, but only if it is accepted.
- take_action_ocimem_b: latch a write op with data jdo[34:3].
- take_no_action_ocimem_a: latch a read op.
- More than one strobe in the same cycle: accept the highest priority only (ocimem_a > ocimem_b > no_action), drop the others, set jtag_overrun.
- Any strobe arriving while mon_busy=1 is dropped and sets jtag_overrun. The address load is dropped too.
- mon_busy rises the cycle after an accepted write/read strobe. It falls the cycle after the op completes.

Arbitration FSM, states IDLE, J_WR, J_RD, J_RDW, C_WR, C_RD, C_RDW:
- IDLE with only one requester pending: grant it.
- IDLE with both pending: grant the requester not in last_grant, then update last_grant.
- CPU request = av_read | av_write. If both are high, treat it as a write.
- J_WR: ram_address=mon_addr, ram_wren=1, ram_wrdata=latched data; mon_addr++ at the end of the cycle; next state IDLE.
- J_RD: ram_address=mon_addr.
- J_RDW: MonDReg <= ram_rddata; mon_addr++; next state IDLE.
- C_WR: ram_address=av_address, ram_wren=1, av_waitrequest=0; next state IDLE. CPU write latency is 1 cycle after acceptance in IDLE.
- C_RD: ram_address=av_address.
- C_RDW: av_readdata=ram_rddata, av_waitrequest=0; next state IDLE.
- av_waitrequest is 1 in every state/cycle other than C_WR and C_RDW.
- CPU inputs must be held stable while av_waitrequest=1 (Avalon rule). If the CPU drops its request mid-transaction, the transaction still completes.
- mon_addr is ADDR_W bits and wraps from 2^ADDR_W-1 to 0.
- ram_wren is 0 in all states except J_WR and C_WR.

Test Plan:
- Address load jdo[34]=1, jdo[17+:8]=0x10; then 3 write strobes with data 0xA,0xB,0xC -> RAM[0x10..0x12]=0xA,0xB,0xC; mon_addr=0x13; mon_busy pulses once per write.
- Load address 0x10, then read strobe -> MonDReg=0xA exactly 3 cycles after the strobe; second read strobe -> 0xB.
- CPU write 0x55 to 0x20 then read 0x20 -> av_waitrequest low 1 cycle after write acceptance; read data 0x55 with waitrequest low on cycle 2.
- JTAG read strobe and CPU read in the same cycle after reset (JTAG_FIRST=1) -> JTAG granted first, CPU second; repeat with both contending -> CPU granted first (alternation).
- Load address 0xFF, write strobe -> mon_addr wraps to 0x00. A second strobe while mon_busy=1 -> dropped, jtag_overrun=1. Next accepted take_action_ocimem_a -> jtag_overrun=0.
- Assert reset_n=0 during C_RD -> av_waitrequest=1, state IDLE, MonDReg=0, no ram_wren pulse after release.
